// File: rtl/parity_tx_pkg.sv
// -----------------------------------------------------------------------------
// parity_tx_pkg
//   Shared definitions for the parity serial transmitter:
//   - tx_state_t : FSM state encoding used by parity_serial_tx
//   - LINE_IDLE / START_BIT / STOP_BIT : serial line levels
//   - word_parity() : parity of a word, even or odd
// -----------------------------------------------------------------------------
package parity_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Widest word the transmitter supports; narrower words are zero-extended,
    // which leaves their parity unchanged.
    localparam int MAX_DATA_W = 16;

    // Even parity when odd == 0 (ones count including parity is even),
    // odd parity when odd == 1.
    function automatic logic word_parity(input logic [MAX_DATA_W-1:0] word,
                                         input logic                  odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/parity_tx_if.sv
// -----------------------------------------------------------------------------
// parity_tx_if
//   Valid/ready word handshake into the parity serial transmitter.
//   Ports (signals):
//     in_valid  producer -> transmitter, in_data is valid
//     in_data   producer -> transmitter, DATA_W-bit word to send
//     in_ready  transmitter -> producer, a word is accepted on valid && ready
//   Modports: master (producer side), slave (transmitter side).
// -----------------------------------------------------------------------------
interface parity_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/parity_tx_baud_cnt.sv
// -----------------------------------------------------------------------------
// parity_tx_baud_cnt
//   Bit-period counter for the serial transmitter. Counts 0..CLKS_PER_BIT-1
//   while run is high and pulses bit_end on the last cycle of each bit period,
//   then reloads to 0 for the next bit.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   asynchronous active-high reset, clears the counter
//     clear    in   synchronous clear (word accepted)
//     run      in   frame in progress, counter advances
//     bit_end  out  high on the final cycle of the current bit period
// -----------------------------------------------------------------------------
module parity_tx_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // With CLKS_PER_BIT == 1 the counter sits at 0 and bit_end is high on
    // every running cycle, so there is no wrap to get wrong.
    assign bit_end = run && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parity_serial_tx.sv
// -----------------------------------------------------------------------------
// parity_serial_tx
//   Accepts one word per valid/ready handshake, computes its parity and sends
//   the frame start(0), DATA_W data bits LSB first, parity, stop(1) on a
//   registered serial line that idles high. One frame in flight, no FIFO.
//   Build option: define PARITY_TX_ODD_EN for odd parity (default even).
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   asynchronous active-high reset, abandons any frame
//     in_if       slave modport of parity_tx_if (in_valid, in_data, in_ready)
//     tx_serial   out  serial line, registered
//     busy        out  frame in progress
//     frame_done  out  one-cycle pulse on the last clock of the stop bit
// -----------------------------------------------------------------------------
module parity_serial_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    parity_tx_if.slave     in_if,
    output logic           tx_serial,
    output logic           busy,
    output logic           frame_done
);

    localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

`ifdef PARITY_TX_ODD_EN
    localparam logic ODD_PARITY = 1'b1;
`else
    localparam logic ODD_PARITY = 1'b0;
`endif

    tx_state_t          state_q,     state_d;
    logic [DATA_W-1:0]  shift_q,     shift_d;
    logic [IDX_W-1:0]   bit_idx_q,   bit_idx_d;
    logic               parity_q,    parity_d;
    logic               tx_serial_q, tx_serial_d;
    logic               in_ready_q,  in_ready_d;
    logic               busy_q,      busy_d;

    logic               accept;
    logic               bit_end;
    logic [DATA_W-1:0]  shift_next;

    assign accept     = in_if.in_valid && in_ready_q;
    assign shift_next = shift_q >> 1;

    parity_tx_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .run     (busy_q),
        .bit_end (bit_end)
    );

    // Next-state logic. tx_serial_d is the line level for the state being
    // entered, so the line is already correct on the first cycle of each bit.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        parity_d    = parity_q;
        tx_serial_d = tx_serial_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        unique case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    shift_d     = in_if.in_data;
                    parity_d    = word_parity(MAX_DATA_W'(in_if.in_data), ODD_PARITY);
                    bit_idx_d   = '0;
                    state_d     = TX_START;
                    tx_serial_d = START_BIT;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                end
            end

            TX_START: begin
                if (bit_end) begin
                    state_d     = TX_DATA;
                    bit_idx_d   = '0;
                    tx_serial_d = shift_q[0];
                end
            end

            TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d     = TX_PARITY;
                        tx_serial_d = parity_q;
                    end else begin
                        shift_d     = shift_next;
                        bit_idx_d   = bit_idx_q + IDX_W'(1);
                        tx_serial_d = shift_next[0];
                    end
                end
            end

            TX_PARITY: begin
                if (bit_end) begin
                    state_d     = TX_STOP;
                    tx_serial_d = STOP_BIT;
                end
            end

            TX_STOP: begin
                if (bit_end) begin
                    state_d     = TX_IDLE;
                    tx_serial_d = LINE_IDLE;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d     = TX_IDLE;
                tx_serial_d = LINE_IDLE;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Reset drops any partly sent frame and returns the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            parity_q    <= 1'b0;
            tx_serial_q <= LINE_IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            parity_q    <= parity_d;
            tx_serial_q <= tx_serial_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign tx_serial      = tx_serial_q;
    assign busy           = busy_q;
    // Decoded from flops only: last baud cycle of the stop bit.
    assign frame_done     = (state_q == TX_STOP) && bit_end;

endmodule

// File: tb/tb_parity_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_serial_tx
//   Directed bench for parity_serial_tx. dut_a uses DATA_W=8, CLKS_PER_BIT=4;
//   dut_b uses DATA_W=8, CLKS_PER_BIT=1. Honours PARITY_TX_ODD_EN.
// -----------------------------------------------------------------------------
module tb_parity_serial_tx;

`ifdef PARITY_TX_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic clk;
    logic rst;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;

    int check_count;
    int error_count;

    parity_tx_if #(.DATA_W(8)) bus_a ();
    parity_tx_if #(.DATA_W(8)) bus_b ();

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus_a),
        .tx_serial  (tx_a),
        .busy       (busy_a),
        .frame_done (done_a)
    );

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus_b),
        .tx_serial  (tx_b),
        .busy       (busy_b),
        .frame_done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Offers a word on dut_a and returns right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = data;
        for (int i = 0; i < 100 && !bus_a.in_ready; i++) @(negedge clk);
        checkOutput("ready_before_accept", 32'(bus_a.in_ready), 32'd1);
        @(posedge clk);
    endtask

    // Checks a full 44-cycle frame on dut_a, starting right after the accept
    // edge. On the first cycle the inputs are changed to keep_valid/next_data.
    task automatic runFrame(input string tag, input logic [7:0] data,
                            input logic par, input logic keep_valid,
                            input logic [7:0] next_data);
        logic [10:0] bits;
        bits = {1'b1, par, data, 1'b0};
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) begin
                    bus_a.in_valid = keep_valid;
                    bus_a.in_data  = next_data;
                end
                checkOutput($sformatf("%s_bit%0d_c%0d_tx", tag, b, c), 32'(tx_a), 32'(bits[b]));
                checkOutput($sformatf("%s_bit%0d_c%0d_done", tag, b, c), 32'(done_a),
                            32'((b == 10) && (c == 3)));
                if (c == 0) begin
                    checkOutput($sformatf("%s_bit%0d_busy", tag, b), 32'(busy_a), 32'd1);
                    checkOutput($sformatf("%s_bit%0d_ready", tag, b), 32'(bus_a.in_ready), 32'd0);
                end
            end
        end
    endtask

    // One idle cycle on dut_a: line high, ready, not busy.
    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, "_idle_tx"},    32'(tx_a),           32'd1);
        checkOutput({tag, "_idle_ready"}, 32'(bus_a.in_ready), 32'd1);
        checkOutput({tag, "_idle_busy"},  32'(busy_a),         32'd0);
        checkOutput({tag, "_idle_done"},  32'(done_a),         32'd0);
    endtask

    initial begin
        logic [10:0] ff_bits;
        check_count    = 0;
        error_count    = 0;
        rst            = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = 8'h00;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = 8'h00;

        // Reset state, held for 10 clocks.
        @(negedge clk);
        checkOutput("rst_tx",    32'(tx_a),           32'd1);
        checkOutput("rst_ready", 32'(bus_a.in_ready), 32'd1);
        checkOutput("rst_busy",  32'(busy_a),         32'd0);
        checkOutput("rst_done",  32'(done_a),         32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("rst_hold_tx", 32'(tx_a), 32'd1);
        end
        rst = 1'b0;
        checkIdle("post_rst");

        // 0xA5: four ones, even parity 0.
        applyStimulus(8'hA5);
        runFrame("a5", 8'hA5, 1'b0 ^ ODD, 1'b0, 8'h00);
        checkIdle("a5");

        // 0x07: three ones, even parity 1.
        applyStimulus(8'h07);
        runFrame("x07", 8'h07, 1'b1 ^ ODD, 1'b0, 8'h00);
        checkIdle("x07");

        // Valid held high: 0x3C, then 0xC3 (presented while busy) after one idle cycle.
        applyStimulus(8'h3C);
        runFrame("x3c", 8'h3C, 1'b0 ^ ODD, 1'b1, 8'hC3);
        checkIdle("b2b");
        @(posedge clk);
        runFrame("xc3", 8'hC3, 1'b0 ^ ODD, 1'b0, 8'h5A);
        checkIdle("xc3");

        // Reset on clock 20 of a frame of zeros: line must jump high asynchronously.
        applyStimulus(8'h00);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        for (int i = 1; i < 20; i++) @(negedge clk);
        checkOutput("mid_tx_before_rst", 32'(tx_a), 32'd0);
        checkOutput("mid_busy_before_rst", 32'(busy_a), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_tx",    32'(tx_a),           32'd1);
        checkOutput("mid_rst_ready", 32'(bus_a.in_ready), 32'd1);
        checkOutput("mid_rst_busy",  32'(busy_a),         32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkIdle("after_mid_rst");
        applyStimulus(8'hA5);
        runFrame("a5_again", 8'hA5, 1'b0 ^ ODD, 1'b0, 8'h00);
        checkIdle("a5_again");

        // CLKS_PER_BIT=1, 0xFF: 11-cycle frame, even parity 0.
        ff_bits = {1'b1, 1'b0 ^ ODD, 8'hFF, 1'b0};
        @(negedge clk);
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 8'hFF;
        checkOutput("b_ready_before", 32'(bus_b.in_ready), 32'd1);
        @(posedge clk);
        for (int b = 0; b < 11; b++) begin
            @(negedge clk);
            if (b == 0) bus_b.in_valid = 1'b0;
            checkOutput($sformatf("b_bit%0d_tx", b), 32'(tx_b), 32'(ff_bits[b]));
            checkOutput($sformatf("b_bit%0d_done", b), 32'(done_b), 32'(b == 10));
            checkOutput($sformatf("b_bit%0d_ready", b), 32'(bus_b.in_ready), 32'd0);
        end
        @(negedge clk);
        checkOutput("b_end_ready", 32'(bus_b.in_ready), 32'd1);
        checkOutput("b_end_tx",    32'(tx_b),           32'd1);
        checkOutput("b_end_busy",  32'(busy_b),         32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

    // Watchdog: the directed sequence is a few thousand cycles at most.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
